ysyx_25010008_isram: RTL and testbench
======================================

YSYX_25010008_ISRAM -- requirements
Module: ysyx_25010008_isram

Interface
REQ-001 SHALL have parameter BASE, default 32'h3000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit words (power of two, 2..65536).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from address handshake to first rvalid (1..15).
REQ-004 SHALL have port clock  input  1  sole clock, rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pvalid  input  1  fetch address valid from initiator.
REQ-007 SHALL have port pc  input  32  fetch byte address.
REQ-008 SHALL have port pready  output  1  responder can accept an address.
REQ-009 SHALL have port rready  input  1  initiator can accept read data.
REQ-010 SHALL have port rvalid  output  1  read data/response valid.
REQ-011 SHALL have port rdata  output  32  instruction word.
REQ-012 SHALL have port rresp  output  2  response code.
REQ-013 SHALL have port wen  input  1  preload write strobe (bench/loader).
REQ-014 SHALL have port waddr  input  32  preload byte address.
REQ-015 SHALL have port wdata  input  32  preload word.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-017 IDLE: pready=1, rvalid=0; pvalid&pready at edge T -> capture response, counter=LATENCY-1, go WAIT (or RESP directly if LATENCY=1).
REQ-018 WAIT: pready=0, rvalid=0; counter decrements each cycle; at counter==0 go RESP, so rvalid first asserts at T+LATENCY.
REQ-019 RESP: rvalid=1, rdata/rresp held stable until rvalid&rready; on that edge return to IDLE.
REQ-020 pready SHALL be 1 only in IDLE; no second address is accepted while a fetch is outstanding (one outstanding transaction).
REQ-021 Response SHALL be computed at the address handshake edge: offset=pc-BASE (32-bit unsigned wrap).
REQ-022 offset>=DEPTH*4 -> rresp=2'b11 (DECERR), rdata=0.
REQ-023 in range and pc[1:0]!=0 -> rresp=2'b10 (SLVERR), rdata=0.
REQ-024 otherwise rresp=2'b00 (OKAY), rdata=array[offset[..:2]].
REQ-025 DECERR SHALL take priority over SLVERR.
REQ-026 wen=1 SHALL write wdata to array[(waddr-BASE)>>2] at the edge if in range and word-aligned; otherwise ignored silently.
REQ-027 Preload writes SHALL be accepted in any FSM state; an in-flight response is unaffected (captured data retained).
REQ-028 Write and address handshake to the same word in the same cycle SHALL return the old word.
REQ-029 rready asserted while not in RESP SHALL have no effect.

Reset
REQ-030 reset SHALL asynchronously force state=IDLE, counter=0, rvalid=0, rdata=0, rresp=0, pready=1 (after reset release).
REQ-031 reset mid-WAIT or mid-RESP SHALL abort the transaction; no response is delivered afterwards.
REQ-032 Array contents SHALL NOT be reset.

Structure
REQ-033 Shared package SHALL hold rresp constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), FSM state encoding, and default BASE.
REQ-034 Storage SHALL be a sub-module ysyx_25010008_isram_array (1 write port, 1 synchronous-capture read port, DEPTH words).

Verification
REQ-035 Preload 0x3000_0000<=32'h0000_0413, LATENCY=2; pvalid with pc=0x3000_0000 handshake at T -> rvalid=1 at T+2, rdata=0x00000413, rresp=00.
REQ-036 rready held 0 for 5 cycles in RESP -> rvalid, rdata, rresp stable all 5 cycles; pready=0; return to IDLE one edge after rready=1.
REQ-037 pc=0x3000_0002 -> rresp=10, rdata=0; pc=0x2FFF_FFFC and pc=0x3000_1000 (DEPTH=1024) -> rresp=11, rdata=0.
REQ-038 Assert reset during WAIT -> rvalid=0 immediately, pready=1 after release, no stale response ever appears.
REQ-039 Back-to-back fetches with rready=1, LATENCY=1 -> one response per 2 cycles, correct data for pc=0x3000_0000,0x3000_0004,0x3000_0008.
REQ-040 wen to 0x3000_0004 with wdata=0xDEADBEEF in the same cycle as handshake on 0x3000_0004 holding 0x00000013 -> rdata=0x00000013; next fetch returns 0xDEADBEEF.

Source files
------------

// File: rtl/ysyx_25010008_isram_pkg.sv
// Shared definitions for the instruction SRAM responder.
// Holds the response codes, the FSM state encoding, the default base
// address and the helper that classifies a fetch address into a response.
package ysyx_25010008_isram_pkg;

  localparam logic [31:0] ISRAM_BASE  = 32'h3000_0000;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Out-of-range wins over misalignment: an address outside the window
  // has no word to be misaligned against.
  function automatic logic [1:0] classify(input logic [31:0] offset,
                                          input logic [31:0] limit,
                                          input logic [1:0]  low);
    logic [1:0] code;
    if (offset >= limit) begin
      code = RESP_DECERR;
    end else if (low != 2'b00) begin
      code = RESP_SLVERR;
    end else begin
      code = RESP_OKAY;
    end
    return code;
  endfunction

endpackage

// File: rtl/ysyx_25010008_isram_array.sv
// Word storage for the instruction SRAM.
// Ports:
//   clock, reset      - clock; reset clears only the read capture register
//   we, widx, wdata   - single write port (word index)
//   re, ridx, rkill   - read capture: on re, rdata takes mem[ridx], or zero
//                       when rkill marks the access as an error response
//   rdata             - captured read word, stable until the next re
// The storage itself is never reset.
module ysyx_25010008_isram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] ridx,
  input  logic          rkill,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];

  // Preload write port.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[widx] <= wdata;
    end
  end

  // Read capture; a write to the same word on the same edge is not yet
  // visible here, so the old word is captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= 32'h0000_0000;
    end else if (re) begin
      rdata <= rkill ? 32'h0000_0000 : mem_r[ridx];
    end
  end

endmodule

// File: rtl/ysyx_25010008_isram.sv
// Instruction SRAM responder with a fixed fetch latency.
// Ports:
//   clock, reset          - rising-edge clock, async active-high reset
//   pvalid, pc, pready    - fetch address handshake
//   rvalid, rready        - response handshake
//   rdata, rresp          - instruction word and response code
//   wen, waddr, wdata     - preload write port, usable in any state
// One fetch may be outstanding. The response is decided at the address
// handshake and held until the initiator accepts it.
module ysyx_25010008_isram
  import ysyx_25010008_isram_pkg::*;
#(
  parameter logic [31:0] BASE    = ISRAM_BASE,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pvalid,
  input  logic [31:0] pc,
  output logic        pready,
  input  logic        rready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        wen,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] LIMIT   = 32'(DEPTH) * 32'd4;
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
  localparam bit          LAT_ONE = (LATENCY == 1);

  state_t      state_r, state_nx;
  logic [3:0]  cnt_r, cnt_nx;
  logic        pready_r, pready_nx;
  logic        rvalid_r, rvalid_nx;
  logic [1:0]  rresp_r, rresp_nx;

  logic [31:0] offset_s;
  logic [31:0] woffset_s;
  logic        hs_s;
  logic        wr_ok_s;
  logic [1:0]  resp_s;

  // Offsets wrap modulo 2^32, so addresses below BASE land far out of range.
  assign offset_s  = pc - BASE;
  assign woffset_s = waddr - BASE;
  assign hs_s      = pvalid & pready_r;
  assign resp_s    = classify(offset_s, LIMIT, pc[1:0]);
  assign wr_ok_s   = wen & (woffset_s < LIMIT) & (waddr[1:0] == 2'b00);

  ysyx_25010008_isram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (wr_ok_s),
    .widx  (woffset_s[AW+1:2]),
    .wdata (wdata),
    .re    (hs_s),
    .ridx  (offset_s[AW+1:2]),
    .rkill (resp_s != RESP_OKAY),
    .rdata (rdata)
  );

  // State, latency counter and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      pready_r <= 1'b1;
      rvalid_r <= 1'b0;
      rresp_r  <= RESP_OKAY;
    end else begin
      state_r  <= state_nx;
      cnt_r    <= cnt_nx;
      pready_r <= pready_nx;
      rvalid_r <= rvalid_nx;
      rresp_r  <= rresp_nx;
    end
  end

  // Next-state and latency countdown.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          cnt_nx = LAT_M1;
          if (LAT_ONE) begin
            state_nx = ST_RESP;
          end else begin
            state_nx = ST_WAIT;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nx = ST_RESP;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (rready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RESP;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state so the
  // ports come straight from flops.
  always_comb begin
    pready_nx = (state_nx == ST_IDLE);
    rvalid_nx = (state_nx == ST_RESP);
    if (hs_s) begin
      rresp_nx = resp_s;
    end else begin
      rresp_nx = rresp_r;
    end
  end

  assign pready = pready_r;
  assign rvalid = rvalid_r;
  assign rresp  = rresp_r;

endmodule

// File: tb/tb_ysyx_25010008_isram.sv
// Directed bench: a LATENCY=2 instance for the main checks and a
// LATENCY=1 instance for back-to-back fetches. Both share the preload port.
module tb_ysyx_25010008_isram;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wen   = 1'b0;
  logic [31:0] waddr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic        pvalid_a = 1'b0, rready_a = 1'b0, pready_a, rvalid_a;
  logic [31:0] pc_a = 32'h0, rdata_a;
  logic [1:0]  rresp_a;

  logic        pvalid_b = 1'b0, rready_b = 1'b0, pready_b, rvalid_b;
  logic [31:0] pc_b = 32'h0, rdata_b;
  logic [1:0]  rresp_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  ysyx_25010008_isram #(.LATENCY(2)) dut_a (
    .clock(clock), .reset(reset), .pvalid(pvalid_a), .pc(pc_a),
    .pready(pready_a), .rready(rready_a), .rvalid(rvalid_a),
    .rdata(rdata_a), .rresp(rresp_a), .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  ysyx_25010008_isram #(.LATENCY(1)) dut_b (
    .clock(clock), .reset(reset), .pvalid(pvalid_b), .pc(pc_b),
    .pready(pready_b), .rready(rready_b), .rvalid(rvalid_b),
    .rdata(rdata_b), .rresp(rresp_b), .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  // One fetch on instance A. Optionally writes wd to the same word on the
  // handshake edge (wr), and optionally overwrites the word with mid_d
  // while the response is pending (mid). hold = cycles rready stays low.
  task automatic fetch_a(input logic [31:0] addr, input logic [31:0] exp_d,
                         input logic [1:0] exp_r, input int hold,
                         input bit wr, input logic [31:0] wd,
                         input bit mid, input logic [31:0] mid_d);
    pvalid_a = 1'b1; pc_a = addr;
    if (wr) begin wen = 1'b1; waddr = addr; wdata = wd; end
    chk("pready_before", {31'b0, pready_a}, 32'd1);
    tick();
    pvalid_a = 1'b0; pc_a = 32'h0; wen = 1'b0;
    chk("rvalid_t1", {31'b0, rvalid_a}, 32'd0);
    chk("pready_t1", {31'b0, pready_a}, 32'd0);
    if (mid) begin wen = 1'b1; waddr = addr; wdata = mid_d; end
    tick();
    wen = 1'b0;
    chk("rvalid_t2m", {31'b0, rvalid_a}, 32'd0);
    tick();
    chk("rvalid_t2", {31'b0, rvalid_a}, 32'd1);
    chk("rdata_t2", rdata_a, exp_d);
    chk("rresp_t2", {30'b0, rresp_a}, {30'b0, exp_r});
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rvalid_hold", {31'b0, rvalid_a}, 32'd1);
      chk("rdata_hold", rdata_a, exp_d);
      chk("rresp_hold", {30'b0, rresp_a}, {30'b0, exp_r});
      chk("pready_hold", {31'b0, pready_a}, 32'd0);
    end
    rready_a = 1'b1;
    tick();
    rready_a = 1'b0;
    chk("rvalid_done", {31'b0, rvalid_a}, 32'd0);
    chk("pready_done", {31'b0, pready_a}, 32'd1);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_rvalid", {31'b0, rvalid_a}, 32'd0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_rresp", {30'b0, rresp_a}, 32'd0);
    chk("rst_pready", {31'b0, pready_a}, 32'd1);

    preload(32'h3000_0000, 32'h0000_0413);
    preload(32'h3000_0004, 32'h0000_0013);
    preload(32'h3000_0008, 32'h0010_0093);
    preload(32'h3000_0FFC, 32'hCAFE_F00D);
    preload(32'h3000_1000, 32'hBAD0_0001);   // out of range: ignored
    preload(32'h3000_0009, 32'hBAD0_0002);   // misaligned: ignored
    preload(32'h2FFF_FFFC, 32'hBAD0_0003);   // below base: ignored

    // rready high while idle does nothing
    rready_a = 1'b1;
    tick();
    rready_a = 1'b0;
    chk("idle_rready_rvalid", {31'b0, rvalid_a}, 32'd0);
    chk("idle_rready_pready", {31'b0, pready_a}, 32'd1);

    fetch_a(32'h3000_0000, 32'h0000_0413, 2'b00, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch_a(32'h3000_0008, 32'h0010_0093, 2'b00, 5, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch_a(32'h3000_0FFC, 32'hCAFE_F00D, 2'b00, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch_a(32'h3000_0002, 32'h0, 2'b10, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch_a(32'h2FFF_FFFC, 32'h0, 2'b11, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch_a(32'h3000_1000, 32'h0, 2'b11, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch_a(32'h3000_1002, 32'h0, 2'b11, 0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Same-edge write returns the old word; the next fetch sees the new one.
    fetch_a(32'h3000_0004, 32'h0000_0013, 2'b00, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    fetch_a(32'h3000_0004, 32'hDEAD_BEEF, 2'b00, 0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Write during an in-flight fetch leaves the captured word alone.
    fetch_a(32'h3000_0000, 32'h0000_0413, 2'b00, 2, 1'b0, 32'h0, 1'b1, 32'h0000_0513);
    fetch_a(32'h3000_0000, 32'h0000_0513, 2'b00, 0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset in the middle of WAIT aborts the fetch.
    pvalid_a = 1'b1; pc_a = 32'h3000_0008;
    tick();
    pvalid_a = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_rvalid_now", {31'b0, rvalid_a}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_pready", {31'b0, pready_a}, 32'd1);
    chk("abort_rdata", rdata_a, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_resp", {31'b0, rvalid_a}, 32'd0);
      tick();
    end

    // Back-to-back on the LATENCY=1 instance: one response every 2 cycles.
    pvalid_b = 1'b1; rready_b = 1'b1; pc_b = 32'h3000_0000;
    tick();
    chk("b2b_v0", {31'b0, rvalid_b}, 32'd1);
    chk("b2b_d0", rdata_b, 32'h0000_0513);
    chk("b2b_p0", {31'b0, pready_b}, 32'd0);
    pc_b = 32'h3000_0004;
    tick();
    chk("b2b_gap0", {31'b0, rvalid_b}, 32'd0);
    chk("b2b_pr0", {31'b0, pready_b}, 32'd1);
    tick();
    chk("b2b_v1", {31'b0, rvalid_b}, 32'd1);
    chk("b2b_d1", rdata_b, 32'hDEAD_BEEF);
    pc_b = 32'h3000_0008;
    tick();
    chk("b2b_gap1", {31'b0, rvalid_b}, 32'd0);
    tick();
    chk("b2b_v2", {31'b0, rvalid_b}, 32'd1);
    chk("b2b_d2", rdata_b, 32'h0010_0093);
    chk("b2b_r2", {30'b0, rresp_b}, 32'd0);
    pvalid_b = 1'b0;
    tick();
    rready_b = 1'b0;
    chk("b2b_end_v", {31'b0, rvalid_b}, 32'd0);
    chk("b2b_end_p", {31'b0, pready_b}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
